// File: rtl/div6_seq_if.sv
// div6_seq_if: start/done handshake and operand/result bus between the
// control FSM (master) and the sequential 6-bit divider (slave).
interface div6_seq_if;
    logic       Start;
    logic [5:0] N;
    logic [5:0] D;
    logic [5:0] Q;
    logic [5:0] R;
    logic       Busy;
    logic       Done;
    logic       DivZero;

    modport master (
        output Start, N, D,
        input  Q, R, Busy, Done, DivZero
    );

    modport slave (
        input  Start, N, D,
        output Q, R, Busy, Done, DivZero
    );
endinterface

// File: rtl/div6_seq.sv
// div6_seq: sequential 6-bit restoring divider, one trial subtraction per
// clock on a ripple subtract path (B inverted, carry-in 1).
// IDLE -> RUN (6 steps) -> DONE (1 cycle) -> IDLE; divide by zero skips RUN.
// Optional feature macro: DIV6_SIGNED_EN (two's complement operands, quotient
// truncated toward zero, remainder takes the sign of N). Default is unsigned.
module div6_seq (
    input  logic          Clock,
    input  logic          Resetn,
    div6_seq_if.slave     bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Trial subtraction P' - {0,D}: returns {carry_out, difference}.
    // carry_out = 1 means no borrow. When there is no borrow the difference
    // is below D, so bit 6 is always zero and is not kept.
    function automatic logic [6:0] trial_sub(input logic [6:0] a, input logic [5:0] b);
        logic [7:0] sum;
        sum = {1'b0, a} + {1'b0, 1'b1, ~b} + 8'd1;
        return {sum[7], sum[5:0]};
    endfunction

`ifdef DIV6_SIGNED_EN
    function automatic logic [5:0] neg6(input logic [5:0] x);
        return ~x + 6'd1;
    endfunction

    function automatic logic [5:0] mag6(input logic [5:0] x);
        return x[5] ? neg6(x) : x;
    endfunction
`endif

    logic [1:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [5:0] q_q, q_d;
    logic [5:0] r_q, r_d;
    logic       dz_q, dz_d;
    logic [5:0] nreg_q, nreg_d;
    logic [5:0] dreg_q, dreg_d;
    logic [5:0] p_q, p_d;
    logic [5:0] quo_q, quo_d;
`ifdef DIV6_SIGNED_EN
    logic       neg_q_q, neg_q_d;
    logic       neg_r_q, neg_r_d;
`endif

    logic [6:0] p_shift;
    logic [6:0] sub;

    // Next-state, datapath step and result capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        nreg_d  = nreg_q;
        dreg_d  = dreg_q;
        p_d     = p_q;
        quo_d   = quo_q;
`ifdef DIV6_SIGNED_EN
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
`endif
        p_shift = {p_q, nreg_q[5]};
        sub     = trial_sub(p_shift, dreg_q);

        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    if (bus.D == 6'd0) begin
                        q_d     = 6'h3F;
                        r_d     = bus.N;
                        dz_d    = 1'b1;
                        state_d = ST_DONE;
                    end else begin
`ifdef DIV6_SIGNED_EN
                        nreg_d  = mag6(bus.N);
                        dreg_d  = mag6(bus.D);
                        neg_q_d = bus.N[5] ^ bus.D[5];
                        neg_r_d = bus.N[5];
`else
                        nreg_d  = bus.N;
                        dreg_d  = bus.D;
`endif
                        p_d     = 6'd0;
                        quo_d   = 6'd0;
                        cnt_d   = 3'd0;
                        dz_d    = 1'b0;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (sub[6]) begin
                    p_d   = sub[5:0];
                    quo_d = {quo_q[4:0], 1'b1};
                end else begin
                    p_d   = p_shift[5:0];
                    quo_d = {quo_q[4:0], 1'b0};
                end
                nreg_d = {nreg_q[4:0], 1'b0};
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'd5) begin
`ifdef DIV6_SIGNED_EN
                    q_d = neg_q_q ? neg6(quo_d) : quo_d;
                    r_d = neg_r_q ? neg6(p_d) : p_d;
`else
                    q_d = quo_d;
                    r_d = p_d;
`endif
                    cnt_d   = 3'd0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state and visible results; reset aborts any operation at once.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            q_q     <= 6'd0;
            r_q     <= 6'd0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    // Working registers; always reloaded on accept, so no reset needed.
    always_ff @(posedge Clock) begin
        nreg_q  <= nreg_d;
        dreg_q  <= dreg_d;
        p_q     <= p_d;
        quo_q   <= quo_d;
`ifdef DIV6_SIGNED_EN
        neg_q_q <= neg_q_d;
        neg_r_q <= neg_r_d;
`endif
    end

    assign bus.Q       = q_q;
    assign bus.R       = r_q;
    assign bus.DivZero = dz_q;
    assign bus.Busy    = (state_q == ST_RUN);
    assign bus.Done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_div6_seq.sv
// tb_div6_seq: directed and randomized checks of div6_seq against an
// arithmetic reference model (honours DIV6_SIGNED_EN when defined).
module tb_div6_seq;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    div6_seq_if bus ();

    div6_seq dut (
        .Clock  (clk),
        .Resetn (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [5:0] n, input logic [5:0] d,
                         output logic [5:0] q, output logic [5:0] r, output logic dz);
        int sn, sd;
        if (d == 6'd0) begin
            q  = 6'h3F;
            r  = n;
            dz = 1'b1;
        end else begin
`ifdef DIV6_SIGNED_EN
            sn = int'($signed(n));
            sd = int'($signed(d));
`else
            sn = int'(n);
            sd = int'(d);
`endif
            q  = 6'(sn / sd);
            r  = 6'(sn % sd);
            dz = 1'b0;
        end
    endtask

    // Called #1 after a rising edge with the DUT idle.
    task automatic do_div(input logic [5:0] n, input logic [5:0] d, input bit restart);
        logic [5:0] eq, er;
        logic       edz;
        int         cyc, busy_cnt;
        model(n, d, eq, er, edz);
        bus.Start = 1'b1;
        bus.N     = n;
        bus.D     = d;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        cyc      = 1;
        busy_cnt = 0;
        while (!bus.Done && cyc < 20) begin
            if (bus.Busy) busy_cnt++;
            if (restart && cyc == 2) begin
                bus.Start = 1'b1;
                bus.N     = 6'd10;
                bus.D     = 6'd3;
            end
            if (restart && cyc == 3) bus.Start = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        check("done_seen",   bus.Done, 1);
        check("latency",     cyc, edz ? 1 : 7);
        check("busy_cycles", busy_cnt, edz ? 0 : 6);
        check("busy_in_done", bus.Busy, 0);
        check("q",  bus.Q, eq);
        check("r",  bus.R, er);
        check("dz", bus.DivZero, edz);
        @(posedge clk); #1;
        check("done_pulse", bus.Done, 0);
    endtask

    initial begin
        int c;
        rst_n     = 1'b0;
        bus.Start = 1'b0;
        bus.N     = 6'd0;
        bus.D     = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_q", bus.Q, 0);
        check("rst_r", bus.R, 0);
        check("rst_busy", bus.Busy, 0);
        check("rst_done", bus.Done, 0);
        check("rst_dz", bus.DivZero, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_div(6'd45, 6'd6, 1'b0);
        do_div(6'd63, 6'd1, 1'b0);
        do_div(6'd7,  6'd9, 1'b0);
        do_div(6'd5,  6'd0, 1'b0);
        do_div(6'd45, 6'd6, 1'b1);

        // Reset during the third RUN cycle of 45/6.
        bus.Start = 1'b1;
        bus.N     = 6'd45;
        bus.D     = 6'd6;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("mid_busy", bus.Busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_q", bus.Q, 0);
        check("abort_r", bus.R, 0);
        check("abort_busy", bus.Busy, 0);
        check("abort_done", bus.Done, 0);
        check("abort_dz", bus.DivZero, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            check("no_done_after_abort", bus.Done, 0);
        end
        do_div(6'd20, 6'd4, 1'b0);

        // Start held high: back-to-back operations every 8 cycles.
        bus.Start = 1'b1;
        bus.N     = 6'd45;
        bus.D     = 6'd6;
        @(posedge clk); #1;
        bus.N = 6'd20;
        bus.D = 6'd4;
        c = 1;
        while (!bus.Done && c < 20) begin @(posedge clk); #1; c++; end
        check("held_lat1", c, 7);
        check("held_q1", bus.Q, 7);
        check("held_r1", bus.R, 3);
        c = 0;
        do begin @(posedge clk); #1; c++; end while (!bus.Done && c < 20);
        bus.Start = 1'b0;
        check("held_period", c, 8);
        check("held_q2", bus.Q, 5);
        check("held_r2", bus.R, 0);
        repeat (2) @(posedge clk);
        #1;

        do_div(6'h33, 6'd4,  1'b0);
        do_div(6'h20, 6'h3F, 1'b0);
        do_div(6'd13, 6'h3C, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [5:0] rn, rd;
            rn = 6'($urandom);
            rd = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
            do_div(rn, rd, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
